y86_mem_arbiter: RTL
====================

# y86_mem_arbiter

Two-master arbiter sharing the single y86 memory bus between the sequential CPU core (port 0) and a second master such as a loader or DMA/debug engine (port 1). Each master uses a request/acknowledge handshake. The arbiter registers the winning request, drives one variable-latency memory transaction, and returns a one-cycle acknowledge with read data. Arbitration is round-robin so neither master can starve the other.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum memory wait cycles; only used when the timeout feature is compiled in

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 (CPU) transaction request
- m0_we  in  1  port 0 write enable (1 = write, 0 = read)
- m0_addr  in  AW  port 0 address
- m0_wdata  in  DW  port 0 write data
- m0_ack  out  1  port 0 completion, one-cycle pulse
- m0_err  out  1  port 0 timeout error, qualifies m0_ack
- m0_rdata  out  DW  port 0 read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: identical meaning for port 1
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
- mem_rdata  in  DW  memory read data
- busy  out  1  FSM not in IDLE
- owner  out  1  port of the current or most recent grant

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port not equal to last_owner.
  - On grant: latch we/addr/wdata into mem_* registers, set owner = last_owner = grant, and go to ACCESS.
- ACCESS:
  - mem_req = 1 and mem_* are held stable.
  - When mem_ack = 1: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), and go to RESP.
- RESP:
  - mX_ack = 1 for exactly one cycle on the owner port only.
  - mX_rdata holds its value until the next read that completes on that port.
  - Next state is IDLE.
- Request rules:
  - A master holds req, we, addr and wdata stable from assertion until it samples ack.
  - The arbiter samples req only in IDLE.
  - A req still high in the IDLE cycle after ack is a new transaction, so back-to-back streaming is legal.
- The arbiter never aborts a granted transaction for a competing request.

## Timing
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, all acks, all errs and busy = 0.
  - mem_addr, mem_wdata, m0_rdata and m1_rdata = 0.
  - owner = last_owner = 1, so port 0 wins the first tie.
- Minimum latency:
  - req high in cycle 0 (IDLE).
  - mem_req high in cycle 1.
  - mem_ack in cycle 1 gives mX_ack in cycle 2.
  - Each memory wait cycle adds one cycle.
- Maximum throughput is one transaction per 3 cycles. Under continuous dual requests, grants alternate 0,1,0,1.
- mem_req drops on the edge that samples mem_ack. mem_ack seen outside ACCESS is ignored.
- rst mid-transaction:
  - Next edge: IDLE, mem_req = 0, no ack issued.
  - Pending transactions are dropped; masters re-request.

## Configuration
- Macro: Y86_MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears on entry to ACCESS and increments on each ACCESS cycle with mem_ack = 0.
  - When the counter reaches TIMEOUT, the arbiter drops mem_req and goes to RESP with mX_err = 1 alongside mX_ack; rdata is unchanged.
  - mem_ack in the same cycle as the timeout takes priority: normal completion, err = 0.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - m0_err and m1_err are tied to 0.

## Test plan
- Reset, then m0 read at 0x10 with mem_ack in cycle 1 and mem_rdata 0x12345678 -> m0_ack in cycle 2 with m0_rdata 0x12345678; m1_ack stays 0.
- m0 and m1 both request in the same cycle after reset -> m0 is granted first, m1 is granted in the IDLE after m0_ack; owner goes 0 then 1.
- Both masters hold req for 6 transactions -> grant order 0,1,0,1,0,1; each ack is 3 cycles apart with a zero-wait memory.
- m1 write of 0xCAFEBABE to 0x40 with mem_ack delayed 4 cycles -> mem_we, mem_addr and mem_wdata are stable for 5 cycles; m1_ack comes 6 cycles after req; m1_rdata is unchanged.
- rst asserted in the middle of ACCESS -> mem_req = 0 and busy = 0 next cycle, with no ack on either port.
- With Y86_MEM_ARB_TIMEOUT_EN and TIMEOUT = 4, memory never acks an m0 read -> mem_req drops after 4 wait cycles, and m0_ack = 1 with m0_err = 1 in the following cycle.

Source files
------------

// File: rtl/y86_mem_arbiter_if.sv
// Request/acknowledge memory bus shared by the y86 masters and the memory.
// The arbiter is a slave on each master port and a master on the memory port.
interface y86_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/y86_mem_arbiter.sv
// Round-robin two-master arbiter for the y86 memory bus.
// Define Y86_MEM_ARB_TIMEOUT_EN to add a memory wait timeout with error.
module y86_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  y86_mem_arbiter_if.slave  m0,
  y86_mem_arbiter_if.slave  m1,
  y86_mem_arbiter_if.master mem,
  output logic busy,
  output logic owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          owner_q;
  logic          any;
  logic          gnt;
  logic          tmo;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign any = m0.req | m1.req;
  // owner_q doubles as last_owner: a tie goes to the other port
  assign gnt = m0.req ? (m1.req & ~owner_q) : 1'b1;

`ifdef Y86_MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ?
                      $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt;
  logic          err0_q;
  logic          err1_q;

  assign tmo    = (cnt == CW'(TIMEOUT - 1));
  assign m0.err = err0_q;
  assign m1.err = err1_q;
`else
  assign tmo    = 1'b0;
  assign m0.err = 1'b0;
  assign m1.err = 1'b0;
`endif

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign m0.ack    = ack0_q;
  assign m1.ack    = ack1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      owner_q  <= 1'b1;
`ifdef Y86_MEM_ARB_TIMEOUT_EN
      cnt      <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
`ifdef Y86_MEM_ARB_TIMEOUT_EN
      err0_q <= 1'b0;
      err1_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any) begin
            state   <= ACCESS;
            req_q   <= 1'b1;
            we_q    <= gnt ? m1.we    : m0.we;
            addr_q  <= gnt ? m1.addr  : m0.addr;
            wdata_q <= gnt ? m1.wdata : m0.wdata;
            owner_q <= gnt;
`ifdef Y86_MEM_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        ACCESS: begin
          if (mem.ack || tmo) begin
            state  <= RESP;
            req_q  <= 1'b0;
            ack0_q <= ~owner_q;
            ack1_q <= owner_q;
            if (mem.ack && !we_q) begin
              if (owner_q) rdata1_q <= mem.rdata;
              else         rdata0_q <= mem.rdata;
            end
`ifdef Y86_MEM_ARB_TIMEOUT_EN
            err0_q <= ~mem.ack & ~owner_q;
            err1_q <= ~mem.ack & owner_q;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
